// File: rtl/de3cd_pkg.sv
// Shared sizing and the per-channel holding-register layout for the tcd1304 channel merger.
package de3cd_pkg;

  localparam int NCH = 10;
  localparam int DW  = 16;
  localparam int IDW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          full;
  } hold_t;

  localparam hold_t HOLD_EMPTY = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary index, pointer advances only when en_i is high.
module rr_arbiter
  import de3cd_pkg::*;
#(
  parameter int N  = NCH,
  parameter int IW = IDW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0]        last_q;
  logic [IW-1:0]        last_d;
  logic [N-1:0]         hi_mask;
  logic [N-1:0]         hi_req;
  logic [N-1:0]         pick;
  logic [N:0][IW-1:0]   idx_acc;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (IW'(gi) > last_q);
  end

  // Requests above the last winner take precedence; otherwise wrap to the lowest request.
  assign hi_req = req_i & hi_mask;
  assign pick   = (|hi_req) ? hi_req : req_i;
  assign gnt_o  = pick & (~pick + N'(1));
  assign any_o  = |req_i;

  assign idx_acc[0] = '0;
  for (gi = 0; gi < N; gi++) begin : g_enc
    assign idx_acc[gi+1] = idx_acc[gi] | (gnt_o[gi] ? IW'(gi) : '0);
  end
  assign idx_o = idx_acc[N];

  always_comb begin
    last_d = last_q;
    if (en_i && any_o) begin
      last_d = idx_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/tcd1304_ch_arbiter.sv
// Merges NCH tcd1304 sample streams into one ready/valid word stream through
// per-channel one-entry holds and a round-robin grant, flagging dropped samples.
module tcd1304_ch_arbiter #(
  parameter int NCH = de3cd_pkg::NCH,
  parameter int DW  = de3cd_pkg::DW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NCH*DW-1:0]             tcd1304_dout,
  input  logic [NCH-1:0]                tcd1304_valid,
  input  logic [NCH-1:0]                tcd1304_frame_start,
  input  logic [NCH-1:0]                ch_enable,
  input  logic                          ovf_clear,
  output logic [DW-1:0]                 m_tdata,
  output logic [de3cd_pkg::IDW-1:0]     m_tid,
  output logic                          m_tsof,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [NCH-1:0]                ovf_flag
);

  localparam int IDW = de3cd_pkg::IDW;

  logic [NCH-1:0]          req;
  logic [NCH-1:0]          gnt;
  logic [NCH-1:0]          ovf_set;
  logic [IDW-1:0]          gnt_idx;
  logic                    gnt_any;
  logic                    load;
  logic [NCH:0][DW-1:0]    data_acc;
  logic [NCH:0]            sof_acc;

  logic [DW-1:0]           tdata_q, tdata_d;
  logic [IDW-1:0]          tid_q, tid_d;
  logic                    tsof_q, tsof_d;
  logic                    tvalid_q, tvalid_d;
  logic [NCH-1:0]          ovf_q, ovf_d;

  // The output register accepts a new word whenever it is empty or being drained.
  assign load = (~tvalid_q | m_tready) & gnt_any;

  rr_arbiter #(
    .N  (NCH),
    .IW (IDW)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .en_i  (load),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign data_acc[0] = '0;
  assign sof_acc[0]  = 1'b0;

  genvar gi;
  for (gi = 0; gi < NCH; gi++) begin : g_ch
    de3cd_pkg::hold_t hold_q;
    de3cd_pkg::hold_t hold_d;
    logic             fire;
    logic             granted;

    assign fire           = tcd1304_valid[gi] & ch_enable[gi];
    assign granted        = load & gnt[gi];
    assign req[gi]        = hold_q.full & ch_enable[gi];
    assign ovf_set[gi]    = fire & hold_q.full & ~granted;
    assign data_acc[gi+1] = data_acc[gi] | (gnt[gi] ? hold_q.data : '0);
    assign sof_acc[gi+1]  = sof_acc[gi] | (gnt[gi] & hold_q.sof);

    // A hold being drained this cycle can take a fresh sample without loss.
    always_comb begin
      hold_d = hold_q;
      if (!ch_enable[gi]) begin
        hold_d = de3cd_pkg::HOLD_EMPTY;
      end else if (fire && (!hold_q.full || granted)) begin
        hold_d.data = tcd1304_dout[gi*DW +: DW];
        hold_d.sof  = tcd1304_frame_start[gi];
        hold_d.full = 1'b1;
      end else if (granted) begin
        hold_d.full = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold_q <= de3cd_pkg::HOLD_EMPTY;
      end else begin
        hold_q <= hold_d;
      end
    end
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tid_d    = tid_q;
    tsof_d   = tsof_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = data_acc[NCH];
      tid_d    = gnt_idx;
      tsof_d   = sof_acc[NCH];
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // A new overflow in the same cycle as a clear leaves the flag set.
  assign ovf_d = (ovf_q & ~{NCH{ovf_clear}}) | ovf_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tsof_q   <= 1'b0;
      ovf_q    <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      tsof_q   <= tsof_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tid    = tid_q;
  assign m_tsof   = tsof_q;
  assign ovf_flag = ovf_q;

endmodule
